// File: rtl/pcm_multi_player_pkg.sv
// pcm_multi_player_pkg
// Shared definitions for the N-channel PCM sample player: register offsets
// inside each channel's 8-entry register window, the end-marker bit position
// in ROM data, and the per-channel playback state record.
// The state record is sized for the widest supported configuration
// (AW up to 24, PW up to 16); voices keep the unused upper bits at zero.
package pcm_multi_player_pkg;

  localparam logic [2:0] REG_PITCH_L = 3'd0;
  localparam logic [2:0] REG_PITCH_H = 3'd1;
  localparam logic [2:0] REG_START_0 = 3'd2;
  localparam logic [2:0] REG_START_1 = 3'd3;
  localparam logic [2:0] REG_START_2 = 3'd4;
  localparam logic [2:0] REG_KEYON   = 3'd5;
  localparam logic [2:0] REG_KEYOFF  = 3'd6;
  localparam logic [2:0] REG_VOLCTL  = 3'd7;

  localparam int END_BIT  = 7;
  localparam int ADDR_MAX = 24;
  localparam int PRE_MAX  = 16;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [PRE_MAX-1:0]  pre;
    logic                active;
    logic [6:0]          sample;
  } voice_state_t;

endpackage

// File: rtl/pcm_voice.sv
// pcm_voice
// One playback channel: its register file (PITCH, START, VOL, LOOP), the
// pitch prescaler, the ROM address counter and end-marker stop/loop handling.
// Ports:
//   CLK, NRES   clock, asynchronous active-low reset
//   wr          register write aimed at this channel
//   wreg, wd    register offset and write data
//   slot_hit    this channel owns the current scheduler slot
//   fetch       RD carries data fetched for this channel this cycle
//   rd          ROM data (bit END_BIT = end marker, 6:0 = sample)
//   addr        current sample address
//   active      channel is playing
//   sample      last latched sample
//   vol         4-bit volume for the mixer
//   end_p       one-cycle pulse on an end-marker fetch
// Supports 17 <= AW <= 24 and 9 <= PW <= 16.
module pcm_voice
  import pcm_multi_player_pkg::*;
#(
  parameter int AW = 17,
  parameter int PW = 12
) (
  input  logic          CLK,
  input  logic          NRES,
  input  logic          wr,
  input  logic [2:0]    wreg,
  input  logic [7:0]    wd,
  input  logic          slot_hit,
  input  logic          fetch,
  input  logic [7:0]    rd,
  output logic [AW-1:0] addr,
  output logic          active,
  output logic [6:0]    sample,
  output logic [3:0]    vol,
  output logic          end_p
);

  localparam logic [ADDR_MAX-1:0] ADDR_MASK = ADDR_MAX'((33'd1 << AW) - 33'd1);
  localparam logic [PRE_MAX-1:0]  PRE_FULL  = PRE_MAX'((17'd1 << PW) - 17'd1);

  logic [PW-1:0] pitch;
  logic [AW-1:0] start;
  logic          loop;
  logic          keyon;
  logic          keyoff;
  voice_state_t  st;

  assign keyon  = wr && (wreg == REG_KEYON);
  assign keyoff = wr && (wreg == REG_KEYOFF);
  assign addr   = st.addr[AW-1:0];
  assign active = st.active;
  assign sample = st.sample;

  // Byte-wide register writes; PITCH and START only matter at the next
  // reload, so the running address and prescaler are left alone here.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      pitch <= '0;
      start <= '0;
      vol   <= '0;
      loop  <= 1'b0;
    end else if (wr) begin
      case (wreg)
        REG_PITCH_L: pitch[7:0]     <= wd;
        REG_PITCH_H: pitch[PW-1:8]  <= wd[PW-9:0];
        REG_START_0: start[7:0]     <= wd;
        REG_START_1: start[15:8]    <= wd;
        REG_START_2: start[AW-1:16] <= wd[AW-17:0];
        REG_VOLCTL: begin
          vol  <= wd[3:0];
          loop <= wd[4];
        end
        default: ;
      endcase
    end
  end

  // Playback state. KEYON beats everything, including an end marker that
  // arrives in the same cycle; the end marker in turn overrides any
  // prescaler step on the address. END_P fires on every end-marker fetch
  // of a playing channel regardless of what else happens that cycle.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      st    <= '0;
      end_p <= 1'b0;
    end else begin
      end_p <= fetch && st.active && rd[END_BIT];
      if (keyon) begin
        st.active <= 1'b1;
        st.addr   <= ADDR_MAX'(start);
        st.pre    <= PRE_MAX'(pitch);
      end else if (keyoff) begin
        st.active <= 1'b0;
      end else if (st.active) begin
        if (slot_hit) begin
          if (st.pre == PRE_FULL) begin
            st.pre  <= PRE_MAX'(pitch);
            st.addr <= (st.addr + ADDR_MAX'(1)) & ADDR_MASK;
          end else begin
            st.pre <= st.pre + PRE_MAX'(1);
          end
        end
        if (fetch) begin
          if (rd[END_BIT]) begin
            if (loop) begin
              st.addr <= ADDR_MAX'(start);
              st.pre  <= PRE_MAX'(pitch);
            end else begin
              st.active <= 1'b0;
            end
          end else begin
            st.sample <= rd[6:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/pcm_multi_player.sv
// pcm_multi_player
// N-channel PCM sample player sharing one external sample ROM through a
// round-robin slot scheduler, with a registered volume-weighted mix.
// Ports:
//   CLK, NRES  clock, asynchronous active-low reset
//   WE, WA, WD register write strobe, {channel, reg[2:0]} address, data
//   SA         registered sample ROM address
//   RD         ROM data, valid one cycle after SA
//   SAMPLE     per-channel latched samples, channel c at [7c+6:7c]
//   MIX        sum of SAMPLE*VOL over a frame, updated at each frame start
//   ACTIVE     per-channel playing flags
//   END_P      per-channel end-marker pulses
module pcm_multi_player
  import pcm_multi_player_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 17,
  parameter int PW  = 12,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              CLK,
  input  logic              NRES,
  input  logic              WE,
  input  logic [CW+2:0]     WA,
  input  logic [7:0]        WD,
  output logic [AW-1:0]     SA,
  input  logic [7:0]        RD,
  output logic [NCH*7-1:0]  SAMPLE,
  output logic [10+CW:0]    MIX,
  output logic [NCH-1:0]    ACTIVE,
  output logic [NCH-1:0]    END_P
);

  localparam int MW = 11 + CW;

  logic [CW-1:0] slot;
  logic [CW-1:0] sa_ch;
  logic [CW-1:0] rd_ch;
  logic          sa_vld;
  logic          rd_vld;
  logic [AW-1:0] v_addr   [NCH];
  logic [6:0]    v_sample [NCH];
  logic [3:0]    v_vol    [NCH];
  logic [MW-1:0] acc;
  logic [MW-1:0] term;

  // One voice per channel; channel indices with no voice never match, so
  // writes to them fall on the floor.
  for (genvar c = 0; c < NCH; c++) begin : g_voice
    pcm_voice #(.AW(AW), .PW(PW)) u_voice (
      .CLK      (CLK),
      .NRES     (NRES),
      .wr       (WE && (WA[CW+2:3] == CW'(c))),
      .wreg     (WA[2:0]),
      .wd       (WD),
      .slot_hit (slot == CW'(c)),
      .fetch    (rd_vld && (rd_ch == CW'(c))),
      .rd       (RD),
      .addr     (v_addr[c]),
      .active   (ACTIVE[c]),
      .sample   (v_sample[c]),
      .vol      (v_vol[c]),
      .end_p    (END_P[c])
    );
    assign SAMPLE[7*c +: 7] = v_sample[c];
  end

  // Weighted contribution of the channel owning the current slot.
  always_comb begin
    term = '0;
    term = MW'(v_sample[slot]) * MW'(v_vol[slot]);
  end

  // Slot scheduler and ROM pipeline: the slot's address goes out on SA,
  // the ROM answers a cycle later, and the channel tag (plus whether the
  // channel was playing when the fetch was issued) travels alongside so
  // the data lands in the right voice. The mixer accumulates one term per
  // slot and publishes the frame total as the slot counter wraps to 0.
  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      slot   <= '0;
      SA     <= '0;
      sa_ch  <= '0;
      sa_vld <= 1'b0;
      rd_ch  <= '0;
      rd_vld <= 1'b0;
      acc    <= '0;
      MIX    <= '0;
    end else begin
      slot   <= (slot == CW'(NCH-1)) ? '0 : slot + CW'(1);
      SA     <= v_addr[slot];
      sa_ch  <= slot;
      sa_vld <= ACTIVE[slot];
      rd_ch  <= sa_ch;
      rd_vld <= sa_vld;
      if (slot == CW'(NCH-1)) begin
        MIX <= acc + term;
        acc <= '0;
      end else begin
        acc <= acc + term;
      end
    end
  end

endmodule

// File: tb/tb_pcm_multi_player.sv
// tb_pcm_multi_player
// Directed bench for pcm_multi_player with NCH=4. A registered ROM model
// answers SA one cycle later. cyc counts rising edges since reset release;
// outputs are sampled on the falling edge, where cyc equals the number of
// the edge just taken. Channel c owns SA after edges with cyc%4 == c+1.
module tb_pcm_multi_player;
  import pcm_multi_player_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 17;
  localparam int PW  = 12;
  localparam int CW  = 2;

  logic             CLK = 1'b0;
  logic             NRES;
  logic             WE;
  logic [CW+2:0]    WA;
  logic [7:0]       WD;
  logic [AW-1:0]    SA;
  logic [7:0]       RD;
  logic [NCH*7-1:0] SAMPLE;
  logic [10+CW:0]   MIX;
  logic [NCH-1:0]   ACTIVE;
  logic [NCH-1:0]   END_P;

  logic [7:0] rom [0:(1<<AW)-1];
  int cyc;
  int checks = 0;
  int errors = 0;

  pcm_multi_player #(.NCH(NCH), .AW(AW), .PW(PW)) dut (
    .CLK    (CLK),
    .NRES   (NRES),
    .WE     (WE),
    .WA     (WA),
    .WD     (WD),
    .SA     (SA),
    .RD     (RD),
    .SAMPLE (SAMPLE),
    .MIX    (MIX),
    .ACTIVE (ACTIVE),
    .END_P  (END_P)
  );

  always #5 CLK = ~CLK;

  // Edge counter since reset release.
  always @(posedge CLK or negedge NRES) begin
    if (!NRES) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Synchronous ROM with one cycle of latency.
  always @(posedge CLK) RD <= rom[SA];

  function automatic logic [6:0] samp(input int c);
    return SAMPLE[7*c +: 7];
  endfunction

  task automatic waitCyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic applyStimulus(input int ch, input logic [2:0] r, input logic [7:0] d);
    WE = 1'b1;
    WA = {2'(ch), r};
    WD = d;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic restart();
    NRES = 1'b0;
    @(negedge CLK);
    NRES = 1'b1;
  endtask

  initial begin
    NRES = 1'b0;
    WE   = 1'b0;
    WA   = '0;
    WD   = '0;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
    for (int i = 0; i < 7; i++) rom[17'h100 + i] = 8'(8'h10 * (i + 1));
    rom[17'h400] = 8'h05;
    rom[17'h401] = 8'h06;
    rom[17'h402] = 8'h07;
    rom[17'h403] = 8'h80;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("rst_sa", 32'(SA), 0);
    checkOutput("rst_sample", 32'(SAMPLE), 0);
    checkOutput("rst_mix", 32'(MIX), 0);
    checkOutput("rst_active", 32'(ACTIVE), 0);
    checkOutput("rst_endp", 32'(END_P), 0);
    NRES = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      waitCyc(i);
      checkOutput("idle_sa", 32'(SA), 0);
    end
    checkOutput("idle_mix", 32'(MIX), 0);

    // ch1: START=0x100, PITCH=0xFFF, VOL=15; one step per frame
    $display("[TB] ch1 full-rate playback");
    restart();
    applyStimulus(1, REG_PITCH_L, 8'hFF);
    applyStimulus(1, REG_PITCH_H, 8'h0F);
    applyStimulus(1, REG_START_1, 8'h01);
    applyStimulus(1, REG_VOLCTL, 8'h0F);
    applyStimulus(1, REG_KEYON, 8'h00);
    waitCyc(6);  checkOutput("a_sa0", 32'(SA), 32'h100);
    waitCyc(7);  checkOutput("a_sa_ch2", 32'(SA), 0);
    waitCyc(8);  checkOutput("a_samp0", 32'(samp(1)), 32'h10);
                 checkOutput("a_mix0", 32'(MIX), 0);
    waitCyc(10); checkOutput("a_sa1", 32'(SA), 32'h101);
    waitCyc(12); checkOutput("a_samp1", 32'(samp(1)), 32'h20);
                 checkOutput("a_mix1", 32'(MIX), 240);
    waitCyc(16); checkOutput("a_mix2", 32'(MIX), 480);
    waitCyc(20); checkOutput("a_samp3", 32'(samp(1)), 32'h40);
                 checkOutput("a_mix3", 32'(MIX), 720);
                 checkOutput("a_active", 32'(ACTIVE), 32'b0010);
    applyStimulus(1, REG_KEYOFF, 8'h00);
    checkOutput("a_keyoff", 32'(ACTIVE), 0);
    waitCyc(22); checkOutput("a_sa_hold", 32'(SA), 32'h104);
    waitCyc(24); checkOutput("a_mix4", 32'(MIX), 960);
    waitCyc(25); checkOutput("a_samp_hold", 32'(samp(1)), 32'h40);

    // ch0 PITCH=0xFFE (every 2 frames), ch2 PITCH=0xFFC (every 4 frames)
    $display("[TB] pitch prescaler rates");
    restart();
    applyStimulus(0, REG_PITCH_L, 8'hFE);
    applyStimulus(0, REG_PITCH_H, 8'h0F);
    applyStimulus(0, REG_START_1, 8'h02);
    applyStimulus(0, REG_KEYON, 8'h00);
    applyStimulus(2, REG_PITCH_L, 8'hFC);
    applyStimulus(2, REG_PITCH_H, 8'h0F);
    applyStimulus(2, REG_START_1, 8'h03);
    applyStimulus(2, REG_KEYON, 8'h00);
    waitCyc(9);  checkOutput("b_ch0_sa9", 32'(SA), 32'h200);
                 checkOutput("b_active1", 32'(ACTIVE), 32'b0101);
    waitCyc(13); checkOutput("b_ch0_sa13", 32'(SA), 32'h201);
    waitCyc(17); checkOutput("b_ch0_sa17", 32'(SA), 32'h201);
    waitCyc(19); checkOutput("b_ch2_sa19", 32'(SA), 32'h300);
    waitCyc(21); checkOutput("b_ch0_sa21", 32'(SA), 32'h202);
    waitCyc(23); checkOutput("b_ch2_sa23", 32'(SA), 32'h300);
    waitCyc(27); checkOutput("b_ch2_sa27", 32'(SA), 32'h301);
    waitCyc(39); checkOutput("b_ch2_sa39", 32'(SA), 32'h301);
    waitCyc(43); checkOutput("b_ch2_sa43", 32'(SA), 32'h302);

    // ch2 LOOP=0, end marker at START+3
    $display("[TB] ch2 stop at end marker");
    restart();
    applyStimulus(2, REG_PITCH_L, 8'hFF);
    applyStimulus(2, REG_PITCH_H, 8'h0F);
    applyStimulus(2, REG_START_1, 8'h04);
    applyStimulus(2, REG_VOLCTL, 8'h02);
    applyStimulus(2, REG_KEYON, 8'h00);
    waitCyc(7);  checkOutput("c_sa0", 32'(SA), 32'h400);
    waitCyc(9);  checkOutput("c_samp0", 32'(samp(2)), 32'h05);
    waitCyc(17); checkOutput("c_samp2", 32'(samp(2)), 32'h07);
    waitCyc(19); checkOutput("c_sa3", 32'(SA), 32'h403);
    waitCyc(20); checkOutput("c_endp_pre", 32'(END_P), 0);
                 checkOutput("c_active_pre", 32'(ACTIVE), 32'b0100);
    waitCyc(21); checkOutput("c_endp", 32'(END_P), 32'b0100);
                 checkOutput("c_active_post", 32'(ACTIVE), 0);
    waitCyc(22); checkOutput("c_endp_once", 32'(END_P), 0);
    waitCyc(24); checkOutput("c_mix", 32'(MIX), 14);
    waitCyc(25); checkOutput("c_samp_hold", 32'(samp(2)), 32'h07);

    // ch3 LOOP=1, same data
    $display("[TB] ch3 loop at end marker");
    restart();
    applyStimulus(3, REG_PITCH_L, 8'hFF);
    applyStimulus(3, REG_PITCH_H, 8'h0F);
    applyStimulus(3, REG_START_1, 8'h04);
    applyStimulus(3, REG_VOLCTL, 8'h11);
    applyStimulus(3, REG_KEYON, 8'h00);
    waitCyc(8);  checkOutput("d_sa0", 32'(SA), 32'h400);
    waitCyc(20); checkOutput("d_sa3", 32'(SA), 32'h403);
    waitCyc(21); checkOutput("d_endp_pre", 32'(END_P), 0);
    waitCyc(22); checkOutput("d_endp", 32'(END_P), 32'b1000);
                 checkOutput("d_active", 32'(ACTIVE), 32'b1000);
                 checkOutput("d_samp_hold", 32'(samp(3)), 32'h07);
    waitCyc(23); checkOutput("d_endp_once", 32'(END_P), 0);
    waitCyc(24); checkOutput("d_sa_restart", 32'(SA), 32'h400);
                 checkOutput("d_mix0", 32'(MIX), 7);
    waitCyc(26); checkOutput("d_samp_loop", 32'(samp(3)), 32'h05);
    waitCyc(28); checkOutput("d_sa_next", 32'(SA), 32'h401);
                 checkOutput("d_mix1", 32'(MIX), 5);

    // ch0 KEYON coinciding with its end-marker fetch, then reset mid-play
    $display("[TB] ch0 keyon against end marker");
    restart();
    applyStimulus(0, REG_PITCH_L, 8'hFF);
    applyStimulus(0, REG_PITCH_H, 8'h0F);
    applyStimulus(0, REG_START_1, 8'h04);
    applyStimulus(0, REG_VOLCTL, 8'h03);
    applyStimulus(0, REG_KEYON, 8'h00);
    waitCyc(21); checkOutput("e_sa3", 32'(SA), 32'h403);
    waitCyc(22);
    applyStimulus(0, REG_KEYON, 8'h00);
    checkOutput("e_active", 32'(ACTIVE), 32'b0001);
    checkOutput("e_endp", 32'(END_P), 32'b0001);
    waitCyc(24); checkOutput("e_mix0", 32'(MIX), 21);
    waitCyc(25); checkOutput("e_sa_restart", 32'(SA), 32'h400);
    waitCyc(27); checkOutput("e_samp", 32'(samp(0)), 32'h05);
    waitCyc(32); checkOutput("e_mix1", 32'(MIX), 15);
    waitCyc(33);
    NRES = 1'b0;
    #1;
    checkOutput("f_sa", 32'(SA), 0);
    checkOutput("f_sample", 32'(SAMPLE), 0);
    checkOutput("f_mix", 32'(MIX), 0);
    checkOutput("f_active", 32'(ACTIVE), 0);
    checkOutput("f_endp", 32'(END_P), 0);
    @(negedge CLK);
    NRES = 1'b1;
    waitCyc(1);  checkOutput("f_first_sa", 32'(SA), 0);
    waitCyc(4);  checkOutput("f_active_after", 32'(ACTIVE), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_multi_player.md
Name: pcm_multi_player

Overview:
- Parametrised, N-channel successor to the team's two-channel 7-bit PCM sample player.
- Shares one external sample ROM through a round-robin slot scheduler.
- Each channel has a pitch prescaler, a start address, an end-marker stop/loop, and 4-bit volume.
- Adds a registered mixed output and per-channel end pulses for interrupt logic.
- Sits between the sound CPU bus and the DAC/mixer path.

Parameters:
- NCH, 4, number of channels (2..8).
- AW, 17, sample ROM address width.
- PW, 12, pitch prescaler width.
- CW, $clog2(NCH), channel index width (derived; not overridden).

Ports:
- CLK  in  1  system clock
- NRES  in  1  asynchronous active-low reset
- WE  in  1  register write strobe, one-cycle pulse
- WA  in  CW+3  register address: {channel, reg[2:0]}
- WD  in  8  write data
- SA  out  AW  sample ROM address
- RD  in  8  ROM data; bit7 = end marker, bits 6:0 = sample
- SAMPLE  out  NCH*7  per-channel latched 7-bit samples; channel c at [7c+6:7c]
- MIX  out  11+CW  registered sum of sample*volume over all channels
- ACTIVE  out  NCH  per-channel playing flag
- END_P  out  NCH  one-cycle pulse when a channel reaches its end marker

Behaviour:
- Reset: every register, ADDR, PRE, slot counter, SAMPLE, MIX, ACTIVE and END_P go to 0. The block is fully synchronous to CLK; NRES is the only asynchronous input.
- Per-channel registers, indexed by reg[2:0]:
  - 0: PITCH[7:0].
  - 1: PITCH[PW-1:8] (upper bits ignored).
  - 2: START[7:0].
  - 3: START[15:8].
  - 4: START[AW-1:16].
  - 5: KEYON strobe (data ignored).
  - 6: KEYOFF strobe (data ignored).
  - 7: VOL[3:0] and LOOP in bit4.
  - A write to channel index >= NCH is ignored.
- KEYON at cycle t: at t+1, ACTIVE=1, ADDR=START, PRE=PITCH. SAMPLE is held until the first valid fetch.
- KEYOFF: at t+1, ACTIVE=0. SAMPLE is held.
- Slot counter:
  - SLOT increments every cycle and wraps from NCH-1 to 0.
  - SA = ADDR[SLOT], registered, so SA changes one cycle after SLOT.
  - ROM latency is one cycle: RD is sampled the cycle after SA presents channel c's address, and that data belongs to channel c.
- Prescaler, updated once per frame in channel c's slot and only while ACTIVE:
  - If PRE == 2^PW-1: PRE <= PITCH and ADDR <= ADDR+1, wrapping modulo 2^AW.
  - Otherwise PRE <= PRE+1.
  - Step rate = fCLK / (NCH * (2^PW - PITCH)).
  - PITCH = 2^PW-1 gives one step per frame.
- Fetch result for an ACTIVE channel:
  - RD[7]=0: SAMPLE[c] <= RD[6:0].
  - RD[7]=1 and LOOP=1: ADDR <= START, PRE <= PITCH, and END_P[c] pulses for one cycle. SAMPLE is held.
  - RD[7]=1 and LOOP=0: ACTIVE <= 0 and END_P[c] pulses for one cycle. SAMPLE is held.
  - Fetches for inactive channels are discarded.
- Simultaneous events:
  - KEYON in the same cycle as that channel's end-marker fetch: KEYON wins. ACTIVE stays 1, ADDR=START, END_P still pulses.
  - Register writes to PITCH/START take effect at the next reload only; the running ADDR and PRE are untouched.
  - Prescaler step and end-marker handling in the same cycle: the end-marker action overrides ADDR.
- MIX:
  - Accumulated as SAMPLE[c]*VOL[c] over one frame.
  - Registered into MIX at the SLOT 0 boundary, so it updates once per NCH cycles.
  - Unsigned; width 11+CW, which never overflows.
- Reset mid-playback: all channels stop immediately. The first fetch after release addresses ADDR 0.

Decomposition:
- Package pcm_multi_player_pkg holds:
  - Register offset constants: REG_PITCH_L, REG_PITCH_H, REG_START_0..2, REG_KEYON, REG_KEYOFF, REG_VOLCTL.
  - END_BIT = 7.
  - The per-channel state struct: addr, pre, active, sample.
- Natural sub-module: pcm_voice. It holds one channel's registers, prescaler, address counter and end/loop logic. It is instantiated NCH times via generate; the slot scheduler and mixer stay in the top level.

Test Plan:
- Reset release, NCH=4 → all outputs 0; SA cycles 0 for every slot; MIX=0.
- ch1: START=0x00100, PITCH=0xFFF, VOL=15, KEYON; ROM returns 0x10,0x20,... → SA for ch1 steps 0x00100,0x00101,... once per 4 cycles; SAMPLE[1] tracks the data; MIX=SAMPLE*15 on the next frame boundary.
- ch0: PITCH=0xFFE → ch0 address advances every 2 frames (8 cycles); ch2: PITCH=0xFFC → every 4 frames.
- ch2: LOOP=0, ROM byte 0x80 at START+3 → END_P[2] pulses once; ACTIVE[2] falls; SAMPLE[2] holds the byte at START+2.
- ch3: LOOP=1, same data → END_P[3] pulses; SA for ch3 returns to START; ACTIVE stays 1.
- ch0: KEYON written in the cycle its end marker is fetched → ACTIVE stays 1, ADDR=START. Separately, NRES asserted mid-play → all outputs 0 next cycle.
